// File: rtl/coin_pkg.sv
// Shared definitions for the coin intake front end.
// Contents:
//   coin_code_t     - 2-bit code for one coin stored in the FIFO.
//   CENTS_N/D/Q     - value of each coin in cents.
//   coin_cents()    - converts a coin code to its value in cents.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_N    = 2'd1,
    COIN_D    = 2'd2,
    COIN_Q    = 2'd3
  } coin_code_t;

  localparam int CENTS_N = 5;
  localparam int CENTS_D = 10;
  localparam int CENTS_Q = 25;

  function automatic logic [7:0] coin_cents(input coin_code_t code);
    logic [7:0] cents;
    case (code)
      COIN_N:  cents = 8'(CENTS_N);
      COIN_D:  cents = 8'(CENTS_D);
      COIN_Q:  cents = 8'(CENTS_Q);
      default: cents = 8'd0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter and rising-edge
// detect on the debounced (stable) level.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   raw        - asynchronous, bouncy sensor level
//   rise       - one-cycle pulse, registered on the edge at which the
//                stable level goes from 0 to 1
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam logic [3:0] LIMIT = 4'(DEBOUNCE_CYCLES);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       stable_reg;
  logic [3:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      count_reg  <= 4'd0;
      rise       <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise      <= 1'b0;
      if (sync2_reg != stable_reg) begin
        // The counter has to have reached the limit before the level is
        // taken, so a new level must be seen on LIMIT+1 consecutive edges.
        if (count_reg == LIMIT) begin
          stable_reg <= sync2_reg;
          count_reg  <= 4'd0;
          rise       <= sync2_reg;
        end else begin
          count_reg <= count_reg + 4'd1;
        end
      end else begin
        count_reg <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/coin_intake_frontend.sv
// Coin intake front end: conditions the three raw coin sensors into clean,
// mutually exclusive one-cycle N_in/D_in/Q_in pulses for the vending FSM.
// Coins are debounced, held in per-channel pending bits, serialised into a
// FIFO (priority Q > D > N) and popped with a minimum idle gap.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   nickel_raw/dime_raw/quarter_raw- raw sensor levels
//   accept_en                      - downstream may take coins
//   N_in/D_in/Q_in                 - one-cycle coin pulses
//   coin_reject                    - one-cycle pulse, coin sent to return chute
//   queue_level                    - FIFO occupancy
// Optional (macro COIN_CREDIT_TOTAL_EN):
//   clear_total                    - zero the running total
//   credit_total                   - saturating running total of popped cents
module coin_intake_frontend
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_DEPTH     = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           nickel_raw,
  input  logic                           dime_raw,
  input  logic                           quarter_raw,
  input  logic                           accept_en,
`ifdef COIN_CREDIT_TOTAL_EN
  input  logic                           clear_total,
  output logic [7:0]                     credit_total,
`endif
  output logic                           N_in,
  output logic                           D_in,
  output logic                           Q_in,
  output logic                           coin_reject,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0] GAP = 4'(GAP_CYCLES);

  // Channel index: 0 = nickel, 1 = dime, 2 = quarter.
  logic [2:0] raw_vec;
  logic [2:0] rise;
  assign raw_vec = {quarter_raw, dime_raw, nickel_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_vec[gi]),
        .rise (rise[gi])
      );
    end
  endgenerate

  logic [2:0]    pending_reg;
  logic [2:0]    pending_next;
  logic [2:0]    eff_pending;
  logic [2:0]    wr_mask;
  coin_code_t    wr_code;
  coin_code_t    mem [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic [3:0]    gap_reg;
  coin_code_t    head;
  logic          full;
  logic          empty;
  logic          do_pop;
  logic          do_write;

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == LW'(QUEUE_DEPTH));
  assign empty = (count_reg == '0);
  assign queue_level = count_reg;

  // A fresh coin event is considered in the same cycle it appears, so the
  // FIFO write lands one edge after the stable level rises.
  assign eff_pending = pending_reg | rise;

  assign do_pop = accept_en && !empty && (gap_reg == 4'd0);
  // A pop frees a slot on the same edge, so a full FIFO still accepts a write.
  assign do_write = (|eff_pending) && (!full || do_pop);

  always_comb begin
    wr_code = COIN_NONE;
    wr_mask = 3'b000;
    if (eff_pending[2]) begin
      wr_code = COIN_Q;
      wr_mask = 3'b100;
    end else if (eff_pending[1]) begin
      wr_code = COIN_D;
      wr_mask = 3'b010;
    end else if (eff_pending[0]) begin
      wr_code = COIN_N;
      wr_mask = 3'b001;
    end
  end

  assign pending_next = eff_pending & ~(do_write ? wr_mask : 3'b000);

  // Storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= wr_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 3'b000;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      gap_reg     <= 4'd0;
      N_in        <= 1'b0;
      D_in        <= 1'b0;
      Q_in        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      // A coin arriving on a channel whose pending bit is already held
      // cannot be stored.
      coin_reject <= |(rise & pending_reg);

      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      case ({do_write, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      N_in <= do_pop && (head == COIN_N);
      D_in <= do_pop && (head == COIN_D);
      Q_in <= do_pop && (head == COIN_Q);

      if (do_pop) begin
        gap_reg <= GAP;
      end else if (gap_reg != 4'd0) begin
        gap_reg <= gap_reg - 4'd1;
      end
    end
  end

`ifdef COIN_CREDIT_TOTAL_EN
  logic [8:0] credit_sum;
  assign credit_sum = {1'b0, credit_total} + {1'b0, coin_cents(head)};

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_total <= 8'd0;
    end else if (clear_total) begin
      credit_total <= 8'd0;
    end else if (do_pop) begin
      credit_total <= credit_sum[8] ? 8'hFF : credit_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_coin_intake_frontend.sv
// Scoreboard bench for coin_intake_frontend with default parameters.
// Stimulus pushes the expected coin pulses (code and, where timing is fixed,
// the cycle) into a queue; a negedge monitor pops and compares every pulse.
module tb_coin_intake_frontend;
  import coin_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nickel_raw = 1'b0;
  logic       dime_raw = 1'b0;
  logic       quarter_raw = 1'b0;
  logic       accept_en = 1'b1;
  logic       N_in;
  logic       D_in;
  logic       Q_in;
  logic       coin_reject;
  logic [2:0] queue_level;
`ifdef COIN_CREDIT_TOTAL_EN
  logic       clear_total = 1'b0;
  logic [7:0] credit_total;
`endif

  coin_intake_frontend dut (
    .clk         (clk),
    .reset       (reset),
    .nickel_raw  (nickel_raw),
    .dime_raw    (dime_raw),
    .quarter_raw (quarter_raw),
    .accept_en   (accept_en),
`ifdef COIN_CREDIT_TOTAL_EN
    .clear_total (clear_total),
    .credit_total(credit_total),
`endif
    .N_in        (N_in),
    .D_in        (D_in),
    .Q_in        (Q_in),
    .coin_reject (coin_reject),
    .queue_level (queue_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses_seen = 0;
  int   rejects_seen = 0;
  logic reject_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("check %s: %0d ok (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(input int ch, input logic v);
    case (ch)
      1: nickel_raw = v;
      2: dime_raw = v;
      default: quarter_raw = v;
    endcase
  endtask

  // Called right after a negedge. The next posedge is sampling edge k, so the
  // pulse is seen at the negedge following edge k+8, where cyc == now + 9.
  task automatic coin(input int ch, input int hold, input bit expect_it, input bit timed);
    exp_t e;
    set_raw(ch, 1'b1);
    if (expect_it) begin
      e.code = ch;
      e.cyc = timed ? cyc + 9 : -1;
      exp_q.push_back(e);
    end
    tick(hold);
    set_raw(ch, 1'b0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int   n;
    int   code;
    exp_t e;
    n = int'(N_in) + int'(D_in) + int'(Q_in);
    if (n != 0) begin
      pulses_seen++;
      code = Q_in ? 3 : (D_in ? 2 : 1);
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL onehot: %0d coin outputs high, expected 1 (cycle %0d)", n, cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: code %0d, expected none (cycle %0d)", code, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.code != code) begin
          errors++;
          $display("FAIL pulse_code: got %0d, expected %0d (cycle %0d)", code, e.code, cyc);
        end else if (e.cyc >= 0 && e.cyc != cyc) begin
          errors++;
          $display("FAIL pulse_cycle: got %0d, expected %0d (code %0d)", cyc, e.cyc, code);
        end else begin
          $display("pulse code %0d ok (cycle %0d)", code, cyc);
        end
      end
    end
    if (coin_reject) begin
      rejects_seen++;
      checks++;
      if (reject_prev) begin
        errors++;
        $display("FAIL reject_width: reject high 2 cycles, expected 1 (cycle %0d)", cyc);
      end
    end
    reject_prev = coin_reject;
  end

  initial begin
    int r0;
    int p0;
    exp_t e;

    // Reset state
    tick(3);
    check("reset_N", int'(N_in), 0);
    check("reset_D", int'(D_in), 0);
    check("reset_Q", int'(Q_in), 0);
    check("reset_reject", int'(coin_reject), 0);
    check("reset_level", int'(queue_level), 0);
    reset = 1'b0;
    tick(2);

    // Single nickel, 8-cycle latency
    coin(1, 6, 1'b1, 1'b1);
    tick(14);
    check("single_level", int'(queue_level), 0);
    check("single_rejects", rejects_seen, 0);
    check("single_drained", exp_q.size(), 0);

    // Bouncing dime, then a 3-cycle glitch
    for (int i = 0; i < 4; i++) begin
      dime_raw = ~i[0];
      tick(1);
    end
    coin(2, 6, 1'b1, 1'b1);
    tick(14);
    check("bounce_drained", exp_q.size(), 0);
    p0 = pulses_seen;
    coin(2, 3, 1'b0, 1'b0);
    tick(15);
    check("glitch_no_pulse", pulses_seen, p0);

    // Three coins on the same edge: Q, D, N, 3 cycles apart
    nickel_raw = 1'b1;
    dime_raw = 1'b1;
    quarter_raw = 1'b1;
    e.code = 3; e.cyc = cyc + 9;  exp_q.push_back(e);
    e.code = 2; e.cyc = cyc + 12; exp_q.push_back(e);
    e.code = 1; e.cyc = cyc + 15; exp_q.push_back(e);
    tick(6);
    nickel_raw = 1'b0;
    dime_raw = 1'b0;
    quarter_raw = 1'b0;
    tick(20);
    check("simul_drained", exp_q.size(), 0);
    check("simul_rejects", rejects_seen, 0);

    // Backpressure: 4 in FIFO, 5th pending, 6th rejected, then drain in order
    accept_en = 1'b0;
    coin(3, 6, 1'b1, 1'b0); tick(8);
    coin(2, 6, 1'b1, 1'b0); tick(8);
    coin(1, 6, 1'b1, 1'b0); tick(8);
    coin(2, 6, 1'b1, 1'b0); tick(8);
    check("bp_level_4", int'(queue_level), 4);
    coin(1, 6, 1'b1, 1'b0); tick(8);
    check("bp_level_full", int'(queue_level), 4);
    r0 = rejects_seen;
    coin(1, 6, 1'b0, 1'b0); tick(8);
    check("bp_reject", rejects_seen - r0, 1);
    check("bp_level_after_reject", int'(queue_level), 4);
    accept_en = 1'b1;
    tick(25);
    check("bp_drained", exp_q.size(), 0);
    check("bp_level_empty", int'(queue_level), 0);

    // Reset mid-operation discards the queue
    accept_en = 1'b0;
    coin(1, 6, 1'b0, 1'b0); tick(8);
    coin(2, 6, 1'b0, 1'b0); tick(8);
    coin(3, 6, 1'b0, 1'b0); tick(8);
    check("rst_level_3", int'(queue_level), 3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_level_0", int'(queue_level), 0);
    check("rst_outputs", int'({N_in, D_in, Q_in, coin_reject}), 0);
    p0 = pulses_seen;
    accept_en = 1'b1;
    tick(20);
    check("rst_no_pulses", pulses_seen, p0);
    check("rst_level_stays_0", int'(queue_level), 0);

`ifdef COIN_CREDIT_TOTAL_EN
    // Credit total (zeroed by the reset above)
    check("credit_after_reset", int'(credit_total), 0);
    coin(3, 6, 1'b1, 1'b0); tick(8);
    coin(3, 6, 1'b1, 1'b0); tick(8);
    coin(2, 6, 1'b1, 1'b0); tick(8);
    coin(1, 6, 1'b1, 1'b0); tick(12);
    check("credit_65", int'(credit_total), 65);
    for (int i = 0; i < 9; i++) begin
      coin(3, 6, 1'b1, 1'b0);
      tick(8);
    end
    tick(6);
    check("credit_saturate", int'(credit_total), 255);
    clear_total = 1'b1;
    tick(1);
    clear_total = 1'b0;
    check("credit_clear", int'(credit_total), 0);
    check("credit_drained", exp_q.size(), 0);
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_intake_frontend.md
Name: coin_intake_frontend

Overview:
- Conditions the three raw coin-sensor lines (nickel, dime, quarter) into clean, single-cycle, mutually exclusive coin pulses.
- Sits directly upstream of the vending FSM and drives its N_in, D_in and Q_in inputs.
- Synchronises and debounces each sensor line.
- Serialises coins that arrive together and queues them while the FSM is busy.
- Returns coins it cannot hold through a reject pulse.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive cycles a synced line must hold a new level before that level is accepted (legal range 1..15).
- QUEUE_DEPTH, default 4: number of entries in the coin FIFO; must be a power of 2, 2..16.
- GAP_CYCLES, default 2: minimum number of idle cycles between two output coin pulses (legal range 0..15).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- nickel_raw  in  1  asynchronous, bouncy nickel sensor level.
- dime_raw  in  1  asynchronous, bouncy dime sensor level.
- quarter_raw  in  1  asynchronous, bouncy quarter sensor level.
- accept_en  in  1  high = downstream FSM may receive coins; low = hold the queue.
- N_in  out  1  one-cycle nickel pulse to the FSM.
- D_in  out  1  one-cycle dime pulse to the FSM.
- Q_in  out  1  one-cycle quarter pulse to the FSM.
- coin_reject  out  1  one-cycle pulse; the coin just detected is routed to the return chute.
- queue_level  out  $clog2(QUEUE_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: synchronous, active-high. At the first rising clk edge with reset=1, all of the following clear to 0:
  - synchroniser flops, debounce counters and stable levels;
  - pending bits and the FIFO pointers;
  - the gap counter;
  - N_in, D_in, Q_in, coin_reject and queue_level.
- Reset taken mid-operation discards queued coins; no pulses are emitted afterwards for them.
- Per-channel front end (×3):
  - 2-flop synchroniser.
  - Debounce counter increments while synced ≠ stable and is zeroed when they match.
  - When the counter reaches DEBOUNCE_CYCLES, stable takes the synced value and the counter zeroes.
  - A stable 0→1 transition is a coin event. A stable 1→0 transition produces nothing.
- Pending stage: one pending bit per channel.
  - A coin event sets that channel's pending bit.
  - If the bit is already set, the new coin is not stored and coin_reject pulses on the next cycle.
- FIFO write:
  - At most one write per cycle; entry is a 2-bit coin code.
  - Priority when several pending bits are set: Q > D > N.
  - The written channel's pending bit clears on the same edge.
  - FIFO full: no write; pending bits hold.
- FIFO read: a read (pop) happens when all of the following hold:
  - accept_en=1;
  - the FIFO is not empty;
  - gap counter = 0.
- On a pop:
  - The matching output (N_in, D_in or Q_in) is registered high for exactly one cycle.
  - The gap counter loads GAP_CYCLES and decrements to 0.
  - At most one of N_in, D_in, Q_in is high in any cycle.
- Simultaneous pop and write in the same cycle are both allowed, including when the FIFO is full; queue_level then stays unchanged.
- accept_en low: no pop; queue and pending bits keep filling normally.
- Latency:
  - Sampling edge k is the first edge at which a raw line is high and stays high.
  - Stable level rises at edge k+2+DEBOUNCE_CYCLES.
  - FIFO write occurs at edge k+3+DEBOUNCE_CYCLES.
  - The pulse is visible after edge k+4+DEBOUNCE_CYCLES, given an empty queue, accept_en=1 and gap=0.
  - Default latency is 8 cycles.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no event.

Optional Feature:
- Macro: COIN_CREDIT_TOTAL_EN.
- Defined: adds input clear_total (1 bit) and output credit_total (8 bits, unsigned cents).
  - On every pop, credit_total adds 5, 10 or 25 for the coin popped, saturating at 255.
  - clear_total=1 zeroes the total; clear wins over a simultaneous pop.
  - reset zeroes the total.
- Undefined: neither port exists and no adder logic is built.

Decomposition:
- Package coin_pkg holds:
  - typedef coin_code_t, 2-bit: COIN_NONE=0, COIN_N=1, COIN_D=2, COIN_Q=3;
  - localparams CENTS_N=5, CENTS_D=10, CENTS_Q=25.
- Sub-module coin_debounce (synchroniser, debounce counter, rise detect; parameter DEBOUNCE_CYCLES), instantiated once per channel.
- The FIFO and arbiter are written inline in coin_intake_frontend.

Test Plan:
- Single coin: nickel_raw high for 6 cycles with defaults → N_in is one cycle wide, 8 cycles after first sample; queue_level returns to 0; no reject.
- Bounce: dime_raw toggles 1-0-1-0 every cycle, then holds 1 for 6 cycles → exactly one D_in pulse; a 3-cycle glitch alone gives no pulse.
- Simultaneous coins: all three raw lines rise on the same edge → pulses Q_in, D_in, N_in in that order, 3 cycles apart (GAP_CYCLES=2); never two outputs high together.
- Backpressure: accept_en=0 while 5 coins are inserted (depth 4) → queue_level=4 and the 5th coin stays pending. Then insert a 6th coin of the same denomination as the 5th → coin_reject=1 for one cycle. Then accept_en=1 → 5 pulses drain in FIFO order.
- Reset mid-operation: queue holds 3 coins, then reset=1 for 1 cycle → queue_level=0, no output pulses afterwards, all outputs 0.
- Credit (COIN_CREDIT_TOTAL_EN defined): drain Q, Q, D, N → credit_total=65. Then insert 9 more quarters (290 cents) → credit_total saturates at 255. Then clear_total=1 → 0.
